// File: rtl/lcd_read_bus.sv
// 8080-style LCD read engine: bursts of RD strobes, samples DB[7:0], returns bytes.
// Optional LCD_READ_DUMMY_EN adds one discarded leading strobe per burst.
module lcd_read_bus #(
    parameter int RD_LOW_CYCLES  = 8,
    parameter int RD_HIGH_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             in_reset,
    input  logic             in_req,
    input  logic             in_rs,
    input  logic [CNT_W-1:0] in_count,
    input  logic [15:0]      in_db,
    output logic             out_busy,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_done,
    output logic             out_rs,
    output logic             out_cs,
    output logic             out_rd,
    output logic             out_wr,
    output logic             out_bus_rel
);

`ifdef LCD_READ_DUMMY_EN
    localparam logic DUMMY = 1'b1;
`else
    localparam logic DUMMY = 1'b0;
`endif

    localparam int TMAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] LOW_LAST  = TW'(RD_LOW_CYCLES - 1);
    localparam logic [TW-1:0] HIGH_LAST = TW'(RD_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_LOW,
        RD_HIGH,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dummy_q, dummy_d;
    logic             busy_q, busy_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             rs_q, rs_d;
    logic             cs_q, cs_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             rel_q, rel_d;

    logic low_end;
    logic high_end;
    logic unused_db;

    assign unused_db = ^in_db[15:8];
    assign low_end   = (state_q == RD_LOW)  && (cnt_q == LOW_LAST);
    assign high_end  = (state_q == RD_HIGH) && (cnt_q == HIGH_LAST);

    always_ff @(posedge clk) begin
        if (in_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dummy_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dummy_q <= dummy_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rs_q    <= rs_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dummy_d = dummy_q;
        case (state_q)
            IDLE: begin
                if (in_req) begin
                    state_d = SETUP;
                    rem_d   = (in_count == '0) ? CNT_W'(1) : in_count;
                    dummy_d = DUMMY;
                end
            end
            SETUP: begin
                state_d = RD_LOW;
                cnt_d   = '0;
            end
            RD_LOW: begin
                if (low_end) begin
                    state_d = RD_HIGH;
                    cnt_d   = '0;
                    // the dummy strobe does not consume a byte of the burst
                    if (dummy_q) begin
                        dummy_d = 1'b0;
                    end else begin
                        rem_d = rem_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_HIGH: begin
                if (high_end) begin
                    cnt_d   = '0;
                    state_d = (rem_q != '0) ? RD_LOW : FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d  = busy_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        rs_d    = rs_q;
        cs_d    = cs_q;
        rd_d    = rd_q;
        wr_d    = 1'b1;
        rel_d   = rel_q;
        case (state_q)
            IDLE: begin
                if (in_req) begin
                    cs_d   = 1'b0;
                    rs_d   = in_rs;
                    rel_d  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            SETUP: begin
                rd_d = 1'b0;
            end
            RD_LOW: begin
                if (low_end) begin
                    rd_d = 1'b1;
                    if (!dummy_q) begin
                        data_d  = in_db[7:0];
                        valid_d = 1'b1;
                    end
                end
            end
            RD_HIGH: begin
                if (high_end) begin
                    if (rem_q != '0) begin
                        rd_d = 1'b0;
                    end else begin
                        cs_d   = 1'b1;
                        rel_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            FINISH: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign out_busy    = busy_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_done    = done_q;
    assign out_rs      = rs_q;
    assign out_cs      = cs_q;
    assign out_rd      = rd_q;
    assign out_wr      = wr_q;
    assign out_bus_rel = rel_q;

endmodule

// File: tb/tb_lcd_read_bus.sv
// Directed bench for lcd_read_bus: burst timing, data capture, ignored requests,
// mid-burst reset; expectations follow LCD_READ_DUMMY_EN when it is defined.
module tb_lcd_read_bus;

`ifdef LCD_READ_DUMMY_EN
    localparam int DM = 1;
`else
    localparam int DM = 0;
`endif

    logic        clk = 1'b0;
    logic        in_reset;
    logic        in_req;
    logic        in_rs;
    logic [7:0]  in_count;
    logic [15:0] in_db;
    logic        out_busy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_done;
    logic        out_rs;
    logic        out_cs;
    logic        out_rd;
    logic        out_wr;
    logic        out_bus_rel;

    int compared   = 0;
    int mismatched = 0;

    int         vcount, strobes, dcount, dcyc, bfall, csrise;
    int         vcyc [8];
    logic [7:0] vdat [8];
    logic [7:0] seq  [4];
    logic       rs0, cs0, rel0;

    lcd_read_bus #(
        .RD_LOW_CYCLES (8),
        .RD_HIGH_CYCLES(4),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .in_reset   (in_reset),
        .in_req     (in_req),
        .in_rs      (in_rs),
        .in_count   (in_count),
        .in_db      (in_db),
        .out_busy   (out_busy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_done   (out_done),
        .out_rs     (out_rs),
        .out_cs     (out_cs),
        .out_rd     (out_rd),
        .out_wr     (out_wr),
        .out_bus_rel(out_bus_rel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs ncyc cycles from the accepting edge (cycle 0) and logs the burst.
    task automatic run(input int ncyc, input int r1, input int r2);
        logic prev_rd;
        vcount  = 0;
        strobes = 0;
        dcount  = 0;
        dcyc    = -1;
        bfall   = -1;
        csrise  = -1;
        prev_rd = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (i == 0) begin
                in_req = 1'b0;
                rs0    = out_rs;
                cs0    = out_cs;
                rel0   = out_bus_rel;
            end
            if (i == r1 || i == r2) in_req = 1'b1;
            else in_req = 1'b0;
            if (out_valid) begin
                if (vcount < 8) begin
                    vcyc[vcount] = i;
                    vdat[vcount] = out_data;
                end
                vcount++;
            end
            if (out_done) begin
                dcount++;
                if (dcyc < 0) dcyc = i;
            end
            if (prev_rd && !out_rd) strobes++;
            if (!prev_rd && out_rd && strobes < 4) in_db = {8'hAB, seq[strobes]};
            if (out_cs && csrise < 0 && i > 0) csrise = i;
            if (!out_busy && bfall < 0 && i > 0) bfall = i;
            prev_rd = out_rd;
        end
        in_req = 1'b0;
    endtask

    initial begin
        in_reset = 1'b1;
        in_req   = 1'b0;
        in_rs    = 1'b0;
        in_count = 8'd0;
        in_db    = 16'h0000;
        tick();
        tick();
        in_reset = 1'b0;
        tick();
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(out_done), 32'd0);
        chk("rst_rs", 32'(out_rs), 32'd0);
        chk("rst_cs", 32'(out_cs), 32'd1);
        chk("rst_rd", 32'(out_rd), 32'd1);
        chk("rst_wr", 32'(out_wr), 32'd1);
        chk("rst_rel", 32'(out_bus_rel), 32'd0);

        // single byte, RS=0
        seq[0] = 8'h5A; seq[1] = 8'h5A; seq[2] = 8'h5A; seq[3] = 8'h5A;
        in_count = 8'd1;
        in_rs    = 1'b0;
        in_db    = 16'hAB5A;
        in_req   = 1'b1;
        run(40, -10, -10);
        chk("t1_cs0", 32'(cs0), 32'd0);
        chk("t1_rel0", 32'(rel0), 32'd1);
        chk("t1_rs0", 32'(rs0), 32'd0);
        chk("t1_strobes", 32'(strobes), 32'(1 + DM));
        chk("t1_vcount", 32'(vcount), 32'd1);
        chk("t1_vcyc", 32'(vcyc[0]), 32'(9 + 12 * DM));
        chk("t1_vdat", 32'(vdat[0]), 32'h5A);
        chk("t1_done_cyc", 32'(dcyc), 32'(13 + 12 * DM));
        chk("t1_dcount", 32'(dcount), 32'd1);
        chk("t1_cs_rise", 32'(csrise), 32'(13 + 12 * DM));
        chk("t1_busy_fall", 32'(bfall), 32'(14 + 12 * DM));
        chk("t1_rel_end", 32'(out_bus_rel), 32'd0);

        // three bytes, RS=1, bus changes each strobe
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        in_count = 8'd3;
        in_rs    = 1'b1;
        in_db    = {8'hAB, seq[0]};
        in_req   = 1'b1;
        run(60, -10, -10);
        chk("t2_rs0", 32'(rs0), 32'd1);
        chk("t2_vcount", 32'(vcount), 32'd3);
        chk("t2_vcyc0", 32'(vcyc[0]), 32'(9 + 12 * DM));
        chk("t2_vcyc1", 32'(vcyc[1]), 32'(21 + 12 * DM));
        chk("t2_vcyc2", 32'(vcyc[2]), 32'(33 + 12 * DM));
        chk("t2_vdat0", 32'(vdat[0]), 32'(seq[DM]));
        chk("t2_vdat1", 32'(vdat[1]), 32'(seq[1 + DM]));
        chk("t2_vdat2", 32'(vdat[2]), 32'(seq[2 + DM]));
        chk("t2_cs_rise", 32'(csrise), 32'(37 + 12 * DM));
        chk("t2_done_cyc", 32'(dcyc), 32'(37 + 12 * DM));

        // count 0 acts as 1
        seq[0] = 8'h3C; seq[1] = 8'hC3; seq[2] = 8'h99; seq[3] = 8'h99;
        in_count = 8'd0;
        in_rs    = 1'b0;
        in_db    = {8'hAB, seq[0]};
        in_req   = 1'b1;
        run(40, -10, -10);
        chk("t3_vcount", 32'(vcount), 32'd1);
        chk("t3_vdat", 32'(vdat[0]), 32'(seq[DM]));
        chk("t3_strobes", 32'(strobes), 32'(1 + DM));
        chk("t3_dcount", 32'(dcount), 32'd1);

        // requests mid-burst and in FINISH are dropped
        seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;
        in_count = 8'd2;
        in_db    = {8'hAB, seq[0]};
        in_req   = 1'b1;
        run(60, 5, 25 + 12 * DM);
        chk("t4_vcount", 32'(vcount), 32'd2);
        chk("t4_strobes", 32'(strobes), 32'(2 + DM));
        chk("t4_dcount", 32'(dcount), 32'd1);
        chk("t4_vdat1", 32'(vdat[1]), 32'(seq[1 + DM]));
        chk("t4_busy_end", 32'(out_busy), 32'd0);
        chk("t4_cs_end", 32'(out_cs), 32'd1);

        // reset during the second data byte's RD low phase
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        in_count = 8'd3;
        in_rs    = 1'b1;
        in_db    = {8'hAB, seq[0]};
        in_req   = 1'b1;
        run(16 + 12 * DM, -10, -10);
        chk("t5_pre_rd", 32'(out_rd), 32'd0);
        chk("t5_pre_vcount", 32'(vcount), 32'd1);
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        chk("t5_rd", 32'(out_rd), 32'd1);
        chk("t5_cs", 32'(out_cs), 32'd1);
        chk("t5_rel", 32'(out_bus_rel), 32'd0);
        chk("t5_busy", 32'(out_busy), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_done", 32'(out_done), 32'd0);
        chk("t5_rs", 32'(out_rs), 32'd0);
        tick();
        seq[0] = 8'h77; seq[1] = 8'h88; seq[2] = 8'h99; seq[3] = 8'h99;
        in_count = 8'd1;
        in_rs    = 1'b0;
        in_db    = {8'hAB, seq[0]};
        in_req   = 1'b1;
        run(40, -10, -10);
        chk("t5_new_vcount", 32'(vcount), 32'd1);
        chk("t5_new_vdat", 32'(vdat[0]), 32'(seq[DM]));
        chk("t5_new_done", 32'(dcyc), 32'(13 + 12 * DM));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
